// File: rtl/mdu_pkg.sv
// Shared encodings for the multicycle multiply/divide unit.
package mdu_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract the divisor.
module mdu_div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             dvd_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;

  // rem < divisor, so a successful subtraction always fits in WIDTH bits
  assign shifted  = {rem, dvd_bit};
  assign q_bit    = (shifted >= {1'b0, divisor});
  assign diff     = shifted[WIDTH-1:0] - divisor;
  assign rem_next = q_bit ? diff : shifted[WIDTH-1:0];

endmodule

// File: rtl/mult_div_unit.sv
// Iterative HI/LO engine: radix-2 Booth multiplier and restoring divider, start/busy/done handshake.
module mult_div_unit import mdu_pkg::*; #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             abort,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  logic [1:0]       state, state_nx;
  logic [CNT_W-1:0] count;
  logic             is_div, zero_flag, neg_q, neg_r, corr, qm1;
  logic [WIDTH:0]   m, upper, booth_sum;
  logic [WIDTH-1:0] lower, rem_nx, res_hi, res_lo;
  logic             q_bit, accept;

  assign accept = start && !abort;

  always_ff @(posedge clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (accept) state_nx = (op[1] && b == '0) ? ST_FIN : ST_CALC;
      ST_CALC: if (abort) state_nx = ST_IDLE;
               else if (count == CNT_W'(1)) state_nx = ST_FIN;
      ST_FIN:  state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Booth add/subtract selected by {current multiplier bit, previous bit}
  always_comb begin
    booth_sum = upper;
    case ({lower[0], qm1})
      2'b01:   booth_sum = upper + m;
      2'b10:   booth_sum = upper - m;
      default: booth_sum = upper;
    endcase
  end

  mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem      (upper[WIDTH-1:0]),
    .dvd_bit  (lower[WIDTH-1]),
    .divisor  (m[WIDTH-1:0]),
    .rem_next (rem_nx),
    .q_bit    (q_bit)
  );

  // MULTU with multiplier MSB set: Booth saw it as negative, add back multiplicand << WIDTH
  always_comb begin
    if (is_div) begin
      res_lo = neg_q ? -lower : lower;
      res_hi = neg_r ? -upper[WIDTH-1:0] : upper[WIDTH-1:0];
    end else begin
      res_lo = lower;
      res_hi = upper[WIDTH-1:0] + (corr ? m[WIDTH-1:0] : '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count     <= '0;
      is_div    <= 1'b0;
      zero_flag <= 1'b0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      corr      <= 1'b0;
      qm1       <= 1'b0;
      m         <= '0;
      upper     <= '0;
      lower     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      div_zero  <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      busy     <= (state_nx == ST_CALC) || (state_nx == ST_FIN);
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        ST_IDLE: if (accept) begin
          count     <= CNT_W'(WIDTH);
          is_div    <= op[1];
          zero_flag <= op[1] && (b == '0);
          upper     <= '0;
          qm1       <= 1'b0;
          if (op[1]) begin
            neg_q <= (op == OP_DIV) && (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r <= (op == OP_DIV) && a[WIDTH-1];
            corr  <= 1'b0;
            lower <= ((op == OP_DIV) && a[WIDTH-1]) ? -a : a;
            m     <= {1'b0, ((op == OP_DIV) && b[WIDTH-1]) ? -b : b};
          end else begin
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            corr  <= (op == OP_MULTU) && b[WIDTH-1];
            lower <= b;
            m     <= {(op == OP_MULT) && a[WIDTH-1], a};
          end
        end
        ST_CALC: if (!abort) begin
          count <= count - CNT_W'(1);
          if (is_div) begin
            upper <= {1'b0, rem_nx};
            lower <= {lower[WIDTH-2:0], q_bit};
          end else begin
            upper <= {booth_sum[WIDTH], booth_sum[WIDTH:1]};
            lower <= {booth_sum[0], lower[WIDTH-1:1]};
            qm1   <= lower[0];
          end
        end
        ST_FIN: if (!abort) begin
          done <= 1'b1;
          if (zero_flag) begin
            div_zero <= 1'b1;
          end else begin
            hi <= res_hi;
            lo <= res_lo;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
